de0qsys_irq_ctrl: RTL and testbench
===================================

// Module: de0qsys_irq_ctrl
// PURPOSE
//  Interrupt aggregator that consumes the timer irq and up to NUM_IRQ-1 other peripheral irqs.
//  Each source is captured as level or rising-edge, latched as pending, masked, and ORed into one CPU irq.
//  The lowest pending index is reported through a 16-bit Avalon-MM slave (same map style as the timer).
// PARAMETERS
//  NUM_IRQ  8   number of irq sources, 1..16; source 0 is the interval timer irq
//  ID_W     4   width of the ACTIVE_ID index field, >= clog2(NUM_IRQ)
// PORTS
//  clk        in   1        system clock; the only clock
//  reset      in   1        synchronous, active-high reset
//  irq_in     in   NUM_IRQ  source irqs, already synchronous to clk
//  address    in   3        word address
//  chipselect in   1        slave select
//  write_n    in   1        active-low write strobe
//  writedata  in   16       write data
//  readdata   out  16       registered read data
//  irq        out  1        registered aggregate irq to the CPU
// BEHAVIOUR
//  Reset, sampled on posedge clk while reset=1: pending, mask, edge_sel, irq_prev, readdata and irq are all 0.
//  Register map (wr = chipselect & ~write_n; bits [15:NUM_IRQ] read 0 and ignore writes):
//   0 PENDING   R; W1C: writing 1 to a bit clears it
//   1 MASK      RW; 1 = source enabled
//   2 EDGE_SEL  RW; 1 = rising-edge capture, 0 = level
//   3 ACTIVE_ID R: bit15 = valid, [ID_W-1:0] = lowest i with pending&mask; all 0 when none
//   4 RAW       R: current irq_in
//   5 FORCE     W: writing 1 sets that pending bit; reads 0
//   6,7         read 0; writes ignored
//  Set event per bit:
//   edge mode:  set = irq_in & ~irq_prev
//   level mode: set = irq_in
//   FORCE write: OR'd into set
//  irq_prev <= irq_in every cycle, regardless of mode.
//  pending_next = set | (pending & ~clr), where clr = W1C data on PENDING write.
//   Set wins over clear in the same cycle, so no event is lost.
//   Level mode: W1C has no lasting effect while the input stays high.
//   Switching a bit to edge mode while its input is high creates no event.
//  irq <= |(pending & mask).
//  Latency:
//   irq_in rises before edge k -> pending=1 after edge k -> irq=1 after edge k+1.
//   W1C at edge k -> irq=0 after edge k+1, if no other source is active.
//  Readdata is registered every cycle from address (chipselect not required), as in the timer.
//   Value appears 1 cycle after address; reads have no side effects.
//  MASK write takes effect on irq one cycle after the MASK register updates.
//  ACTIVE_ID is combinational from current pending&mask, then registered through readdata.
//  Reset asserted mid-operation clears all state that cycle.
//   After reset deasserts, level inputs still high re-pend on the next edge.
// STRUCTURE
//  Shared package de0qsys_irq_pkg:
//   address localparams ADDR_PENDING..ADDR_FORCE
//   ACTIVE_VALID_BIT = 15
//  Sub-module irq_prio_enc: purely combinational lowest-set-bit encoder.
//   Parameters NUM_IRQ, ID_W; outputs valid and index.
//  Top module holds the registers, edge detect, bus decode and read mux.
// TESTING
//  1 Reset: after reset, read addrs 0-5 -> all 0x0000; irq=0.
//  2 Edge: EDGE_SEL=0x0001, MASK=0x0001; pulse irq_in[0] one cycle.
//    -> pending=0x0001, irq=1 one cycle later, ACTIVE_ID=0x8000.
//    -> W1C 0x0001 -> irq=0 next cycle.
//  3 Level: MASK=0x0004, irq_in[2] held high, W1C 0x0004 -> PENDING still 0x0004, irq stays 1.
//    -> drop irq_in[2], W1C -> 0x0000.
//  4 Priority/mask: irq_in=0x00A0 level, MASK=0x0080 -> ACTIVE_ID=0x8007.
//    -> MASK=0x00A0 -> ACTIVE_ID=0x8005.
//  5 Collision: EDGE_SEL=0x0002; W1C 0x0002 in the same cycle irq_in[1] rises.
//    -> PENDING bit1 = 1 (set wins).
//  6 FORCE: write 0x0010 to FORCE with MASK=0x0010 -> PENDING=0x0010, irq=1.
//    -> read addr 5 -> 0x0000; addr 6 -> 0x0000.

Source files
------------

// File: rtl/de0qsys_irq_pkg.sv
// Shared definitions for the DE0 Qsys interrupt aggregator: register map and field positions.
package de0qsys_irq_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] ADDR_PENDING   = 3'd0;
    localparam logic [2:0] ADDR_MASK      = 3'd1;
    localparam logic [2:0] ADDR_EDGE_SEL  = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE_ID = 3'd3;
    localparam logic [2:0] ADDR_RAW       = 3'd4;
    localparam logic [2:0] ADDR_FORCE     = 3'd5;

    localparam int ACTIVE_VALID_BIT = 15;

endpackage

// File: rtl/de0qsys_irq_ctrl_prio_enc.sv
// Combinational lowest-set-bit encoder; index is 0 when nothing is requested.
module irq_prio_enc #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 4
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    index
);

    always_comb begin
        valid = |req;
        index = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/de0qsys_irq_ctrl.sv
// Interrupt aggregator: level/edge capture, pending latch, mask, lowest-index report over Avalon-MM.
module de0qsys_irq_ctrl
    import de0qsys_irq_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq
);

    logic [NUM_IRQ-1:0] pending_reg;
    logic [NUM_IRQ-1:0] mask_reg;
    logic [NUM_IRQ-1:0] edge_sel_reg;
    logic [NUM_IRQ-1:0] irq_prev_reg;

    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [NUM_IRQ-1:0] force_vec;
    logic [NUM_IRQ-1:0] wr_bits;

    logic               wr_en;
    logic               act_valid;
    logic [ID_W-1:0]    act_index;
    logic [15:0]        active_id;
    logic [15:0]        readdata_next;

    assign wr_en     = chipselect & ~write_n;
    assign wr_bits   = writedata[NUM_IRQ-1:0];
    assign clr_vec   = (wr_en && address == ADDR_PENDING) ? wr_bits : '0;
    assign force_vec = (wr_en && address == ADDR_FORCE)   ? wr_bits : '0;

    if (NUM_IRQ < 16) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = &{1'b0, writedata[15:NUM_IRQ]};
    end

    // A set event always beats a W1C on the same bit so no edge is dropped.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
        assign set_vec[gi] = (edge_sel_reg[gi] ? (irq_in[gi] & ~irq_prev_reg[gi]) : irq_in[gi])
                           | force_vec[gi];
        assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
    end

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (pending_reg & mask_reg),
        .valid (act_valid),
        .index (act_index)
    );

    always_comb begin
        active_id                   = '0;
        active_id[ID_W-1:0]         = act_index;
        active_id[ACTIVE_VALID_BIT] = act_valid;
    end

    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_PENDING:   readdata_next = 16'(pending_reg);
            ADDR_MASK:      readdata_next = 16'(mask_reg);
            ADDR_EDGE_SEL:  readdata_next = 16'(edge_sel_reg);
            ADDR_ACTIVE_ID: readdata_next = active_id;
            ADDR_RAW:       readdata_next = 16'(irq_in);
            default:        readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg  <= '0;
            mask_reg     <= '0;
            edge_sel_reg <= '0;
            irq_prev_reg <= '0;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            pending_reg  <= pending_next;
            irq_prev_reg <= irq_in;
            readdata     <= readdata_next;
            irq          <= |(pending_reg & mask_reg);
            if (wr_en && address == ADDR_MASK) begin
                mask_reg <= wr_bits;
            end
            if (wr_en && address == ADDR_EDGE_SEL) begin
                edge_sel_reg <= wr_bits;
            end
        end
    end

endmodule

// File: tb/tb_de0qsys_irq_ctrl.sv
// Bench for de0qsys_irq_ctrl: directed scenarios plus random traffic against a per-source model.
module tb_de0qsys_irq_ctrl;

    localparam int NUM = 8;
    localparam int IDW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NUM-1:0]  irq_in = '0;
    logic [2:0]      address = '0;
    logic            chipselect = 1'b0;
    logic            write_n = 1'b1;
    logic [15:0]     writedata = '0;
    logic [15:0]     readdata;
    logic            irq;

    int total = 0;
    int passed = 0;
    bit model_valid = 1'b0;

    // Behavioural model: one bit array per register, updated per source.
    bit         m_pend [NUM];
    bit         m_mask [NUM];
    bit         m_edge [NUM];
    bit         m_prev [NUM];
    logic [15:0] m_rd = '0;
    logic        m_irq = 1'b0;

    de0qsys_irq_ctrl #(.NUM_IRQ(NUM), .ID_W(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] a, input logic [NUM-1:0] raw);
        logic [15:0] r;
        r = 16'h0000;
        case (a)
            3'd0: for (int i = 0; i < NUM; i++) r[i] = m_pend[i];
            3'd1: for (int i = 0; i < NUM; i++) r[i] = m_mask[i];
            3'd2: for (int i = 0; i < NUM; i++) r[i] = m_edge[i];
            3'd3: begin
                for (int i = 0; i < NUM; i++) begin
                    if (m_pend[i] && m_mask[i] && r == 16'h0000) r = 16'h8000 + 16'(i);
                end
            end
            3'd4: r = 16'(raw);
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM; i++) begin
                m_pend[i] = 0; m_mask[i] = 0; m_edge[i] = 0; m_prev[i] = 0;
            end
            m_rd  = 16'h0000;
            m_irq = 1'b0;
        end else begin
            bit wr;
            bit any;
            wr = chipselect && !write_n;
            m_rd = model_read(address, irq_in);
            any = 0;
            for (int i = 0; i < NUM; i++) any = any | (m_pend[i] & m_mask[i]);
            m_irq = any;
            for (int i = 0; i < NUM; i++) begin
                bit event_i;
                event_i = irq_in[i] && (!m_edge[i] || !m_prev[i]);
                if (wr && address == 3'd5 && writedata[i]) event_i = 1;
                if (event_i) m_pend[i] = 1;
                else if (wr && address == 3'd0 && writedata[i]) m_pend[i] = 0;
            end
            for (int i = 0; i < NUM; i++) begin
                if (wr && address == 3'd1) m_mask[i] = writedata[i];
                if (wr && address == 3'd2) m_edge[i] = writedata[i];
                m_prev[i] = irq_in[i];
            end
        end
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_readdata", readdata, m_rd);
            chk("model_irq", {15'h0, irq}, {15'h0, m_irq});
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic read_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] d;
        bus_read(a, d);
        chk(name, d, exp);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        for (int a = 0; a < 6; a++) read_chk("reset_read", 3'(a), 16'h0000);
        chk("reset_irq", {15'h0, irq}, 16'h0000);

        // Edge capture and W1C
        bus_write(3'd2, 16'h0001);
        bus_write(3'd1, 16'h0001);
        irq_in = 8'h01;
        @(negedge clk);
        irq_in = 8'h00;
        read_chk("edge_pending", 3'd0, 16'h0001);
        chk("edge_irq", {15'h0, irq}, 16'h0001);
        read_chk("edge_active_id", 3'd3, 16'h8000);
        bus_write(3'd0, 16'h0001);
        @(negedge clk);
        chk("edge_w1c_irq", {15'h0, irq}, 16'h0000);

        // Level: W1C has no lasting effect while input is high
        bus_write(3'd1, 16'h0004);
        irq_in = 8'h04;
        repeat (2) @(negedge clk);
        bus_write(3'd0, 16'h0004);
        read_chk("level_pending_held", 3'd0, 16'h0004);
        chk("level_irq_held", {15'h0, irq}, 16'h0001);
        irq_in = 8'h00;
        @(negedge clk);
        bus_write(3'd0, 16'h0004);
        read_chk("level_pending_cleared", 3'd0, 16'h0000);

        // Priority and mask
        irq_in = 8'hA0;
        bus_write(3'd1, 16'h0080);
        @(negedge clk);
        read_chk("prio_active_7", 3'd3, 16'h8007);
        bus_write(3'd1, 16'h00A0);
        read_chk("prio_active_5", 3'd3, 16'h8005);
        read_chk("raw_read", 3'd4, 16'h00A0);
        irq_in = 8'h00;
        @(negedge clk);
        bus_write(3'd0, 16'h00FF);
        bus_write(3'd1, 16'h0000);

        // Collision: set wins over same-cycle W1C
        bus_write(3'd2, 16'h0002);
        @(negedge clk);
        irq_in = 8'h02;
        bus_write(3'd0, 16'h0002);
        read_chk("collision_pending", 3'd0, 16'h0002);
        irq_in = 8'h00;
        bus_write(3'd0, 16'h0002);
        read_chk("collision_cleared", 3'd0, 16'h0000);

        // FORCE
        bus_write(3'd1, 16'h0010);
        bus_write(3'd5, 16'h0010);
        read_chk("force_pending", 3'd0, 16'h0010);
        chk("force_irq", {15'h0, irq}, 16'h0001);
        read_chk("force_read5", 3'd5, 16'h0000);
        read_chk("force_read6", 3'd6, 16'h0000);

        // Random traffic, including occasional mid-run reset
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 99) == 0);
            irq_in     = NUM'($urandom);
            address    = 3'($urandom);
            chipselect = $urandom_range(0, 1) == 1;
            write_n    = $urandom_range(0, 2) != 0;
            writedata  = 16'($urandom);
            @(negedge clk);
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
